// File: rtl/cache_mem_arbiter_if.sv
// Signal bundle between the two cache controllers, the refill/write-back arbiter and the memory bridge.
// The slave modport is the arbiter's view; master is the caches-plus-bridge side.
interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128,
    parameter int RET_W  = 32
);
    logic              i_rd_req;
    logic [2:0]        i_rd_type;
    logic [ADDR_W-1:0] i_rd_addr;
    logic              i_rd_rdy;
    logic              i_ret_valid;
    logic              i_ret_last;

    logic              d_rd_req;
    logic [2:0]        d_rd_type;
    logic [ADDR_W-1:0] d_rd_addr;
    logic              d_rd_rdy;
    logic              d_ret_valid;
    logic              d_ret_last;

    logic [RET_W-1:0]  ret_data;

    logic              d_wr_req;
    logic [2:0]        d_wr_type;
    logic [ADDR_W-1:0] d_wr_addr;
    logic [3:0]        d_wr_wstrb;
    logic [LINE_W-1:0] d_wr_data;
    logic              d_wr_rdy;

    logic              mem_rd_req;
    logic [2:0]        mem_rd_type;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_rd_rdy;
    logic              mem_ret_valid;
    logic              mem_ret_last;
    logic [RET_W-1:0]  mem_ret_data;

    logic              mem_wr_req;
    logic [2:0]        mem_wr_type;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [3:0]        mem_wr_wstrb;
    logic [LINE_W-1:0] mem_wr_data;
    logic              mem_wr_rdy;

    modport slave (
        input  i_rd_req, i_rd_type, i_rd_addr,
               d_rd_req, d_rd_type, d_rd_addr,
               d_wr_req, d_wr_type, d_wr_addr, d_wr_wstrb, d_wr_data,
               mem_rd_rdy, mem_ret_valid, mem_ret_last, mem_ret_data, mem_wr_rdy,
        output i_rd_rdy, i_ret_valid, i_ret_last,
               d_rd_rdy, d_ret_valid, d_ret_last, ret_data, d_wr_rdy,
               mem_rd_req, mem_rd_type, mem_rd_addr,
               mem_wr_req, mem_wr_type, mem_wr_addr, mem_wr_wstrb, mem_wr_data
    );

    modport master (
        output i_rd_req, i_rd_type, i_rd_addr,
               d_rd_req, d_rd_type, d_rd_addr,
               d_wr_req, d_wr_type, d_wr_addr, d_wr_wstrb, d_wr_data,
               mem_rd_rdy, mem_ret_valid, mem_ret_last, mem_ret_data, mem_wr_rdy,
        input  i_rd_rdy, i_ret_valid, i_ret_last,
               d_rd_rdy, d_ret_valid, d_ret_last, ret_data, d_wr_rdy,
               mem_rd_req, mem_rd_type, mem_rd_addr,
               mem_wr_req, mem_wr_type, mem_wr_addr, mem_wr_wstrb, mem_wr_data
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares one memory bridge between icache and dcache: round-robin serialised refills
// plus a single-entry dcache write-back buffer that blocks same-line reads until drained.
//
// state   | meaning
// IDLE    | no read outstanding; pick an eligible requester
// RD_REQ  | latched read presented to bridge, waiting for mem_rd_rdy
// RD_WAIT | routing return beats to the granted cache until the last beat
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128,
    parameter int OFF_W  = 4,
    parameter int RET_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    cache_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RD_REQ = 2'd1, RD_WAIT = 2'd2} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              grant_d;
    logic [2:0]        rd_type;
    logic [ADDR_W-1:0] rd_addr;
    logic              i_elig;
    logic              d_elig;
    logic              pick_d;

    logic              wbuf_valid;
    logic [2:0]        wbuf_type;
    logic [ADDR_W-1:0] wbuf_addr;
    logic [3:0]        wbuf_wstrb;
    logic [LINE_W-1:0] wbuf_data;

    assign i_elig = bus.i_rd_req &&
                    !(wbuf_valid && bus.i_rd_addr[ADDR_W-1:OFF_W] == wbuf_addr[ADDR_W-1:OFF_W]);
    assign d_elig = bus.d_rd_req &&
                    !(wbuf_valid && bus.d_rd_addr[ADDR_W-1:OFF_W] == wbuf_addr[ADDR_W-1:OFF_W]);
    // grant_d doubles as last_grant: it only changes when a new grant is made
    assign pick_d = d_elig && (!i_elig || !grant_d);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            grant_d <= 1'b0;
            rd_type <= '0;
            rd_addr <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && (i_elig || d_elig)) begin
                grant_d <= pick_d;
                rd_type <= pick_d ? bus.d_rd_type : bus.i_rd_type;
                rd_addr <= pick_d ? bus.d_rd_addr : bus.i_rd_addr;
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        bus.mem_rd_req  = 1'b0;
        bus.i_rd_rdy    = 1'b0;
        bus.d_rd_rdy    = 1'b0;
        bus.i_ret_valid = 1'b0;
        bus.i_ret_last  = 1'b0;
        bus.d_ret_valid = 1'b0;
        bus.d_ret_last  = 1'b0;
        case (state)
            IDLE: begin
                if (i_elig || d_elig) state_nxt = RD_REQ;
            end
            RD_REQ: begin
                bus.mem_rd_req = 1'b1;
                if (bus.mem_rd_rdy) begin
                    bus.i_rd_rdy = !grant_d;
                    bus.d_rd_rdy = grant_d;
                    state_nxt    = RD_WAIT;
                end
            end
            RD_WAIT: begin
                bus.i_ret_valid = !grant_d && bus.mem_ret_valid;
                bus.i_ret_last  = !grant_d && bus.mem_ret_last;
                bus.d_ret_valid = grant_d && bus.mem_ret_valid;
                bus.d_ret_last  = grant_d && bus.mem_ret_last;
                if (bus.mem_ret_valid && bus.mem_ret_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.mem_rd_type = rd_type;
    assign bus.mem_rd_addr = rd_addr;
    assign bus.ret_data    = bus.mem_ret_data[RET_W-1:0];

    // A drain cycle never refills: capture waits for the cycle after the clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wbuf_valid <= 1'b0;
            wbuf_type  <= '0;
            wbuf_addr  <= '0;
            wbuf_wstrb <= '0;
            wbuf_data  <= '0;
        end else if (wbuf_valid) begin
            if (bus.mem_wr_rdy) wbuf_valid <= 1'b0;
        end else if (bus.d_wr_req) begin
            wbuf_valid <= 1'b1;
            wbuf_type  <= bus.d_wr_type;
            wbuf_addr  <= bus.d_wr_addr;
            wbuf_wstrb <= bus.d_wr_wstrb;
            wbuf_data  <= bus.d_wr_data;
        end
    end

    assign bus.d_wr_rdy     = !wbuf_valid;
    assign bus.mem_wr_req   = wbuf_valid;
    assign bus.mem_wr_type  = wbuf_type;
    assign bus.mem_wr_addr  = wbuf_addr;
    assign bus.mem_wr_wstrb = wbuf_wstrb;
    assign bus.mem_wr_data  = wbuf_data;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios then random traffic, checked every cycle
// against a transaction-level model of grants, beat routing and the write buffer.
module tb_cache_mem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;

    cache_mem_arbiter_if bus ();

    cache_mem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // model of the arbiter at transaction level
    bit          m_busy, m_issued, m_own_d, m_last_d, m_wocc;
    int          m_beats;
    logic [31:0] m_addr;
    logic [2:0]  m_type;
    logic [2:0]  m_wtype;
    logic [31:0] m_waddr;
    logic [3:0]  m_wstrb;
    logic [127:0] m_wdata;
    bit          i_acc, d_acc;

    // observations for directed checks
    logic [31:0] obs_i_beats[$];
    bit          obs_grants[$];
    int          obs_i_rdy, obs_i_last, obs_d_ret, obs_rd_req;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit same_line(input logic [31:0] a, input logic [31:0] b);
        return a[31:4] == b[31:4];
    endfunction

    function automatic logic [31:0] rand_addr();
        return 32'h1000 | ($urandom_range(0, 7) << 4) | $urandom_range(0, 15);
    endfunction

    task automatic model_clear();
        m_busy = 0; m_issued = 0; m_own_d = 0; m_last_d = 0; m_wocc = 0; m_beats = 0;
        i_acc = 0; d_acc = 0;
    endtask

    task automatic obs_clear();
        obs_i_beats.delete(); obs_grants.delete();
        obs_i_rdy = 0; obs_i_last = 0; obs_d_ret = 0; obs_rd_req = 0;
    endtask

    task automatic idle_inputs();
        bus.i_rd_req = 0; bus.i_rd_type = 0; bus.i_rd_addr = 0;
        bus.d_rd_req = 0; bus.d_rd_type = 0; bus.d_rd_addr = 0;
        bus.d_wr_req = 0; bus.d_wr_type = 0; bus.d_wr_addr = 0;
        bus.d_wr_wstrb = 0; bus.d_wr_data = 0;
        bus.mem_rd_rdy = 0; bus.mem_ret_valid = 0; bus.mem_ret_last = 0;
        bus.mem_ret_data = 0; bus.mem_wr_rdy = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctl"}, {bus.i_rd_rdy, bus.i_ret_valid, bus.i_ret_last, bus.d_rd_rdy,
                            bus.d_ret_valid, bus.d_ret_last, bus.mem_rd_req, bus.mem_rd_type,
                            bus.mem_wr_req, bus.mem_wr_type, bus.mem_wr_wstrb}, 0);
        chk({tag, "_rd_addr"}, bus.mem_rd_addr, 0);
        chk({tag, "_wr_addr"}, bus.mem_wr_addr, 0);
        chk({tag, "_wr_data"}, bus.mem_wr_data, 0);
        chk({tag, "_ret_data"}, bus.ret_data, 0);
        chk({tag, "_wr_rdy"}, bus.d_wr_rdy, 1);
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        @(posedge clk); #1;
        check_reset_outputs("rst");
        @(posedge clk); #1;
        reset = 0;
        model_clear();
    endtask

    // Called mid-cycle: compare outputs with the model, then advance the model to the next edge
    task automatic check_cycle();
        bit ie, de;
        i_acc = 0; d_acc = 0;
        if (bus.i_ret_valid) obs_i_beats.push_back(bus.ret_data);
        if (bus.i_ret_last) obs_i_last++;
        if (bus.d_ret_valid) obs_d_ret++;
        if (bus.i_rd_rdy) obs_i_rdy++;
        if (bus.mem_rd_req) obs_rd_req++;
        if (bus.i_rd_rdy || bus.d_rd_rdy) obs_grants.push_back(bus.d_rd_rdy);

        chk("ret_data", bus.ret_data, bus.mem_ret_data);
        chk("d_wr_rdy", bus.d_wr_rdy, !m_wocc);
        chk("mem_wr_req", bus.mem_wr_req, m_wocc);
        if (m_wocc) begin
            chk("mem_wr_addr", bus.mem_wr_addr, m_waddr);
            chk("mem_wr_data", bus.mem_wr_data, m_wdata);
            chk("mem_wr_attr", {bus.mem_wr_type, bus.mem_wr_wstrb}, {m_wtype, m_wstrb});
        end

        if (!m_busy) begin
            chk("idle_rd_req", bus.mem_rd_req, 0);
            chk("idle_rdy", {bus.i_rd_rdy, bus.d_rd_rdy}, 0);
            chk("idle_ret", {bus.i_ret_valid, bus.i_ret_last, bus.d_ret_valid, bus.d_ret_last}, 0);
            ie = bus.i_rd_req && !(m_wocc && same_line(bus.i_rd_addr, m_waddr));
            de = bus.d_rd_req && !(m_wocc && same_line(bus.d_rd_addr, m_waddr));
            if (ie || de) begin
                if (ie && de) m_own_d = !m_last_d;
                else          m_own_d = de;
                m_last_d = m_own_d;
                m_busy = 1; m_issued = 0; m_beats = 0;
                m_addr = m_own_d ? bus.d_rd_addr : bus.i_rd_addr;
                m_type = m_own_d ? bus.d_rd_type : bus.i_rd_type;
            end
        end else if (!m_issued) begin
            chk("req_rd_req", bus.mem_rd_req, 1);
            chk("req_addr", bus.mem_rd_addr, m_addr);
            chk("req_type", bus.mem_rd_type, m_type);
            chk("req_rdy", {bus.i_rd_rdy, bus.d_rd_rdy},
                bus.mem_rd_rdy ? (m_own_d ? 2'b01 : 2'b10) : 2'b00);
            chk("req_ret", {bus.i_ret_valid, bus.i_ret_last, bus.d_ret_valid, bus.d_ret_last}, 0);
            if (bus.mem_rd_rdy) begin
                m_issued = 1;
                if (m_own_d) d_acc = 1; else i_acc = 1;
            end
        end else begin
            chk("wait_rd_req", bus.mem_rd_req, 0);
            chk("wait_rdy", {bus.i_rd_rdy, bus.d_rd_rdy}, 0);
            chk("ret_route", {bus.i_ret_valid, bus.i_ret_last, bus.d_ret_valid, bus.d_ret_last},
                m_own_d ? {2'b00, bus.mem_ret_valid, bus.mem_ret_last}
                        : {bus.mem_ret_valid, bus.mem_ret_last, 2'b00});
            if (bus.mem_ret_valid) begin
                m_beats++;
                if (bus.mem_ret_last) m_busy = 0;
            end
        end

        if (m_wocc) begin
            if (bus.mem_wr_rdy) m_wocc = 0;
        end else if (bus.d_wr_req) begin
            m_wocc = 1;
            m_wtype = bus.d_wr_type; m_waddr = bus.d_wr_addr;
            m_wstrb = bus.d_wr_wstrb; m_wdata = bus.d_wr_data;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk); #1;
    endtask

    // Bridge emulation: accepts reads and returns four-beat lines, optionally with random stalls
    task automatic bridge_auto(input bit rnd);
        bit v;
        bus.mem_ret_data = $urandom;
        if (m_busy && !m_issued) begin
            bus.mem_rd_rdy    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.mem_ret_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.mem_ret_last  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        end else if (m_busy) begin
            v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.mem_rd_rdy    = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.mem_ret_valid = v;
            bus.mem_ret_last  = v && (m_beats == 3);
        end else begin
            bus.mem_rd_rdy    = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.mem_ret_valid = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
            bus.mem_ret_last  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    endtask

    task automatic finish_read(input string tag);
        for (int c = 0; c < 40 && m_busy; c++) begin
            bridge_auto(0);
            tick();
            if (i_acc) bus.i_rd_req = 0;
            if (d_acc) bus.d_rd_req = 0;
        end
        chk({tag, "_drained"}, m_busy, 0);
        bus.mem_rd_rdy = 0; bus.mem_ret_valid = 0; bus.mem_ret_last = 0; bus.mem_ret_data = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        obs_clear();
        do_reset();

        // single icache refill, bridge accepts on the second request cycle
        bus.i_rd_req = 1; bus.i_rd_addr = 32'h1C00_0040; bus.i_rd_type = 3'd4;
        tick();
        tick();
        chk("t1_rd_addr", bus.mem_rd_addr, 32'h1C00_0040);
        bus.mem_rd_rdy = 1;
        tick();
        bus.i_rd_req = 0; bus.mem_rd_rdy = 0;
        for (int b = 0; b < 4; b++) begin
            bus.mem_ret_valid = 1; bus.mem_ret_last = (b == 3); bus.mem_ret_data = 32'hA0 + b;
            tick();
        end
        bus.mem_ret_valid = 0; bus.mem_ret_last = 0; bus.mem_ret_data = 0;
        tick();
        chk("t1_beats", obs_i_beats.size(), 4);
        for (int b = 0; b < 4 && b < obs_i_beats.size(); b++)
            chk("t1_beat_data", obs_i_beats[b], 32'hA0 + b);
        chk("t1_rdy_pulses", obs_i_rdy, 1);
        chk("t1_last", obs_i_last, 1);
        chk("t1_no_d_ret", obs_d_ret, 0);

        // contention from reset, both keep requesting
        do_reset();
        obs_clear();
        bus.i_rd_req = 1; bus.i_rd_addr = 32'h100;
        bus.d_rd_req = 1; bus.d_rd_addr = 32'h200;
        for (int c = 0; c < 80 && obs_grants.size() < 4; c++) begin
            bridge_auto(0);
            tick();
            if (i_acc) bus.i_rd_addr += 32'h10;
            if (d_acc) bus.d_rd_addr += 32'h10;
        end
        bus.i_rd_req = 0; bus.d_rd_req = 0;
        finish_read("t2");
        chk("t2_grants", obs_grants.size(), 4);
        for (int g = 0; g < 4 && g < obs_grants.size(); g++)
            chk("t2_order_is_d", obs_grants[g], (g % 2 == 0));

        // write buffer fill, then a same-line read blocked behind it
        bus.d_wr_req = 1; bus.d_wr_addr = 32'h0000_1230; bus.d_wr_type = 3'd7;
        bus.d_wr_data = {4{32'h1111_1111}}; bus.d_wr_wstrb = 4'hF; bus.mem_wr_rdy = 0;
        tick();
        bus.d_wr_req = 0;
        chk("t3_wr_rdy_low", bus.d_wr_rdy, 0);
        chk("t3_wr_req", bus.mem_wr_req, 1);
        bus.d_rd_req = 1; bus.d_rd_addr = 32'h0000_123C; bus.d_rd_type = 3'd2;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t4_raw_block", bus.mem_rd_req, 0);
        end
        bus.mem_wr_rdy = 1;
        tick();
        bus.mem_wr_rdy = 0;
        chk("t3_wr_rdy_back", bus.d_wr_rdy, 1);
        chk("t4_still_idle", bus.mem_rd_req, 0);
        tick();
        chk("t4_raw_grant", bus.mem_rd_req, 1);
        chk("t4_raw_addr", bus.mem_rd_addr, 32'h0000_123C);
        finish_read("t4a");

        // different line is not blocked by a full buffer
        bus.d_wr_req = 1; bus.d_wr_data = {4{32'h2222_2222}};
        tick();
        bus.d_wr_req = 0;
        bus.d_rd_req = 1; bus.d_rd_addr = 32'h0000_1240;
        tick();
        chk("t4_nohit_grant", bus.mem_rd_req, 1);
        chk("t4_nohit_addr", bus.mem_rd_addr, 32'h0000_1240);
        finish_read("t4b");
        bus.mem_wr_rdy = 1;
        tick();
        bus.mem_wr_rdy = 0;

        // same-line write and read together with an empty buffer: read goes first
        bus.d_wr_req = 1; bus.d_wr_addr = 32'h0000_1300;
        bus.d_rd_req = 1; bus.d_rd_addr = 32'h0000_1304;
        tick();
        bus.d_wr_req = 0;
        chk("t4_same_cycle_grant", bus.mem_rd_req, 1);
        chk("t4_same_cycle_wbuf", bus.d_wr_rdy, 0);
        finish_read("t4c");
        bus.mem_wr_rdy = 1;
        tick();
        bus.mem_wr_rdy = 0;

        // stray return beats while idle
        bus.mem_ret_valid = 1; bus.mem_ret_last = 1; bus.mem_ret_data = 32'hDEAD_BEEF;
        tick();
        chk("t6_stray", {bus.i_ret_valid, bus.d_ret_valid}, 0);
        bus.mem_ret_valid = 0; bus.mem_ret_last = 0; bus.mem_ret_data = 0;
        tick();

        // reset in the middle of a refill, after two beats
        bus.i_rd_req = 1; bus.i_rd_addr = 32'h1C00_0080;
        tick();
        bus.mem_rd_rdy = 1;
        tick();
        bus.i_rd_req = 0; bus.mem_rd_rdy = 0;
        for (int b = 0; b < 2; b++) begin
            bus.mem_ret_valid = 1; bus.mem_ret_data = 32'hB0 + b;
            tick();
        end
        idle_inputs();
        #2 reset = 1;
        #1 check_reset_outputs("t5");
        model_clear();
        @(posedge clk); #1;
        reset = 0;
        obs_clear();
        bus.i_rd_req = 1; bus.i_rd_addr = 32'h1C00_00C0;
        tick();
        chk("t5_regrant", bus.mem_rd_req, 1);
        chk("t5_addr", bus.mem_rd_addr, 32'h1C00_00C0);
        finish_read("t5");
        chk("t5_beats", obs_i_beats.size(), 4);
        chk("t5_rdy_pulses", obs_i_rdy, 1);

        // random traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if (i_acc) bus.i_rd_req = 0;
            if (d_acc) bus.d_rd_req = 0;
            if (!bus.i_rd_req && $urandom_range(0, 2) == 0) begin
                bus.i_rd_req = 1; bus.i_rd_addr = rand_addr(); bus.i_rd_type = 3'($urandom_range(0, 7));
            end
            if (!bus.d_rd_req && $urandom_range(0, 2) == 0) begin
                bus.d_rd_req = 1; bus.d_rd_addr = rand_addr(); bus.d_rd_type = 3'($urandom_range(0, 7));
            end
            bus.d_wr_req   = ($urandom_range(0, 2) == 0);
            bus.d_wr_addr  = rand_addr();
            bus.d_wr_type  = 3'($urandom_range(0, 7));
            bus.d_wr_wstrb = 4'($urandom_range(0, 15));
            bus.d_wr_data  = {$urandom, $urandom, $urandom, $urandom};
            bus.mem_wr_rdy = ($urandom_range(0, 2) == 0);
            bridge_auto(1);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
